alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 98 +++++++++
 tb/tb_alu_issue_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one ALU operation at a time, waits SETTLE_CYC cycles, captures and returns the result.
module alu_issue_ctrl #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    output logic        alu_rst_n,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_ctrl,
    output logic [2:0]  alu_bonus,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_cout,
    input  logic        alu_ovf,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_cout,
    output logic        rsp_ovf,
    output logic        rsp_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, CAPTURE, RESP} state_t;
    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [6:0]  op_map;
    logic        legal, accept;
    assign legal     = cmd_op < 4'd12;
    assign cmd_ready = state == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = state == RESP;
    assign alu_rst_n = state == ISSUE || state == SETTLE || state == CAPTURE;
    always_comb begin
        op_map = 7'b0000_000;
        case (cmd_op)
            4'd1:    op_map = 7'b0001_000;
            4'd2:    op_map = 7'b0010_000;
            4'd3:    op_map = 7'b0110_000;
            4'd4:    op_map = 7'b1100_000;
            4'd5:    op_map = 7'b1101_000;
            4'd6:    op_map = 7'b0111_000;
            4'd7:    op_map = 7'b0111_001;
            4'd8:    op_map = 7'b0111_010;
            4'd9:    op_map = 7'b0111_011;
            4'd10:   op_map = 7'b0111_110;
            4'd11:   op_map = 7'b0111_100;
            default: op_map = 7'b0000_000;
        endcase
    end
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? (legal ? ISSUE : RESP) : IDLE;
            ISSUE:   state_nxt = SETTLE;
            SETTLE:  state_nxt = cnt == 4'd0 ? CAPTURE : SETTLE;
            CAPTURE: state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n || !(state inside {IDLE, ISSUE, SETTLE, CAPTURE, RESP})) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            alu_src1   <= 32'd0;
            alu_src2   <= 32'd0;
            alu_ctrl   <= 4'd0;
            alu_bonus  <= 3'd0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && legal) begin
                alu_src1               <= cmd_a;
                alu_src2               <= cmd_b;
                {alu_ctrl, alu_bonus}  <= op_map;
            end
            // Illegal opcodes skip the ALU and report an error response directly.
            if (state == IDLE && accept && !legal)
                {rsp_err, rsp_ovf, rsp_cout, rsp_zero, rsp_result} <= {1'b1, 35'd0};
            if (state == ISSUE)
                cnt <= 4'(SETTLE_CYC - 1);
            if (state == SETTLE && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == CAPTURE)
                {rsp_err, rsp_ovf, rsp_cout, rsp_zero, rsp_result} <= {1'b0, alu_ovf, alu_cout, alu_zero, alu_result};
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random commands against an ALU stub and an opcode-level reference model.
module tb_alu_issue_ctrl;
    localparam int SC = 2;
    localparam logic [3:0] CTRL_TAB [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101,
                                             4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
    localparam logic [2:0] BONUS_TAB [12] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                              3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b100};
    logic        clk = 0, rst_n = 0, cmd_valid = 0, rsp_ready = 0;
    logic [3:0]  cmd_op = 0;
    logic [31:0] cmd_a = 0, cmd_b = 0;
    logic        cmd_ready, alu_rst_n, alu_zero, alu_cout, alu_ovf;
    logic        rsp_valid, rsp_zero, rsp_cout, rsp_ovf, rsp_err;
    logic [31:0] alu_src1, alu_src2, alu_result, rsp_result;
    logic [3:0]  alu_ctrl;
    logic [2:0]  alu_bonus;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    alu_issue_ctrl #(.SETTLE_CYC(SC)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_cout(alu_cout), .alu_ovf(alu_ovf), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );
    // Opcode semantics: returns {ovf, cout, zero, result}.
    function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v;
        c = 0; v = 0; s = 0; r = 0;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
            3: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
            4: r = ~(a | b);
            5: r = ~(a & b);
            6: r = {31'd0, $signed(a) <  $signed(b)};
            7: r = {31'd0, $signed(a) >  $signed(b)};
            8: r = {31'd0, $signed(a) <= $signed(b)};
            9: r = {31'd0, $signed(a) >= $signed(b)};
            10: r = {31'd0, a == b};
            11: r = {31'd0, a != b};
            default: r = 0;
        endcase
        return {v, c, r == 32'd0, r};
    endfunction
    // ALU stub: garbage while disabled or for an unknown control pair.
    function automatic logic [34:0] alu_stub(input logic en, input logic [3:0] ctrl, input logic [2:0] bonus,
                                             input logic [31:0] a, input logic [31:0] b);
        if (!en) return '1;
        for (int i = 0; i < 12; i++)
            if (CTRL_TAB[i] == ctrl && BONUS_TAB[i] == bonus) return model(4'(i), a, b);
        return {3'b111, 32'hBAD0BAD0};
    endfunction
    assign {alu_ovf, alu_cout, alu_zero, alu_result} = alu_stub(alu_rst_n, alu_ctrl, alu_bonus, alu_src1, alu_src2);
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk); #1;
    endtask
    // One command end to end; hold = cycles rsp_ready stays low in RESP.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [34:0] e;
        logic        legal;
        int          lat;
        legal = op < 4'd12;
        e = legal ? model(op, a, b) : 35'd0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1;
        chk("cmd_ready_idle", cmd_ready, 1);
        step();
        cmd_valid = 0; cmd_op = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            chk("alu_en_inflight", alu_rst_n, legal);
            chk("cmd_ready_busy", cmd_ready, 0);
            if (legal) begin
                chk("alu_ctrl", alu_ctrl, CTRL_TAB[op]);
                chk("alu_bonus", alu_bonus, BONUS_TAB[op]);
                chk("alu_src1", alu_src1, a);
                chk("alu_src2", alu_src2, b);
            end
            step();
            lat++;
        end
        // Edges after the accept edge until rsp_valid is seen; illegal ops respond on the accept edge.
        chk("latency", lat, legal ? SC + 2 : 0);
        chk("rsp_result", rsp_result, e[31:0]);
        chk("rsp_flags", {rsp_ovf, rsp_cout, rsp_zero}, e[34:32]);
        chk("rsp_err", rsp_err, !legal);
        chk("alu_en_resp", alu_rst_n, 0);
        if (legal) chk("alu_src_held", {alu_src1, alu_src2}, {a, b});
        cmd_valid = 1; cmd_op = 4'd2;
        repeat (hold) begin
            step();
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_data", {rsp_err, rsp_ovf, rsp_cout, rsp_zero, rsp_result}, {!legal, e});
            chk("cmd_ready_resp", cmd_ready, 0);
        end
        rsp_ready = 1;
        chk("cmd_ready_handshake", cmd_ready, 0);
        step();
        rsp_ready = 0; cmd_valid = 0;
        chk("rsp_valid_done", rsp_valid, 0);
        chk("cmd_ready_done", cmd_ready, 1);
    endtask
    initial begin
        rst_n = 0; cmd_valid = 1; cmd_op = 4'd2; cmd_a = 32'd7; cmd_b = 32'd9;
        repeat (2) step();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_en", alu_rst_n, 0);
        chk("rst_alu_regs", {alu_src1, alu_src2, alu_ctrl, alu_bonus}, 0);
        chk("rst_rsp_regs", {rsp_err, rsp_ovf, rsp_cout, rsp_zero, rsp_result}, 0);
        rst_n = 1; cmd_valid = 0;
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_no_accept", {alu_rst_n, rsp_valid}, 0);
        run(4'd2, 32'h7FFFFFFF, 32'd1, 0);
        run(4'd3, 32'd5, 32'd5, 1);
        run(4'd6, 32'hFFFFFFFF, 32'd1, 0);
        run(4'd13, 32'h1234, 32'h5678, 0);
        run(4'd2, 32'hFFFFFFFF, 32'd1, 10);
        // Reset while the ALU is settling drops the operation.
        cmd_op = 4'd0; cmd_a = 32'hF0F0F0F0; cmd_b = 32'hFFFF0000; cmd_valid = 1;
        step();
        cmd_valid = 0;
        step();
        chk("settle_alu_en", alu_rst_n, 1);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("abort_alu_en", alu_rst_n, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        repeat (8) begin
            step();
            chk("abort_no_rsp", rsp_valid, 0);
        end
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            int pick;
            pick = $urandom_range(0, 3);
            a = pick == 0 ? 32'h7FFFFFFF : pick == 1 ? 32'h80000000 : $urandom;
            pick = $urandom_range(0, 3);
            b = pick == 0 ? a : pick == 1 ? 32'hFFFFFFFF : $urandom;
            run(4'($urandom_range(0, 15)), a, b, $urandom_range(0, 3));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
